core_dispatch_queue: RTL and testbench



---
 rtl/core_dispatch_queue.sv | 120 ++++++++++++
 tb/tb_core_dispatch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatch_queue.sv
// Per-core dispatch queue: in-order FIFO between the arbiter and a core fetch stage.
// The head is held back while its memory operand collides with the peer core's destination.
module core_dispatch_queue #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned PTR_W   = 5,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push_valid,
  input  logic [31:0]        push_instr,
  output logic               push_ready,
  input  logic               flush,
  output logic               core_valid,
  output logic [31:0]        core_instr,
  input  logic               core_ready,
  input  logic               peer_busy,
  input  logic [11:0]        peer_dest,
  output logic [PTR_W:0]     count,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int unsigned  INSTR_W   = 32;
  localparam int unsigned  FIELD_W   = 12;
  localparam int unsigned  CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [STALL_W-1:0] r_stall;

  logic [INSTR_W-1:0] w_head;
  logic [FIELD_W-1:0] w_src;
  logic [FIELD_W-1:0] w_dst;
  logic               w_src_hit;
  logic               w_dst_hit;
  logic               w_hazard;
  logic               w_empty;
  logic               w_full;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [PTR_W-1:0]   w_nxt_wr_ptr;
  logic [PTR_W-1:0]   w_nxt_rd_ptr;
  logic [CNT_W-1:0]   w_nxt_count;
  logic               w_nxt_overflow;
  logic [STALL_W-1:0] w_nxt_stall;

  // Head decode and cross-core hazard; a field with its mode bit set is a register operand.
  assign w_head    = r_mem[r_rd_ptr];
  assign w_src     = {w_head[23], w_head[10:0]};
  assign w_dst     = {w_head[22], w_head[21:11]};
  assign w_src_hit = ~w_head[23] & (w_src == peer_dest);
  assign w_dst_hit = ~w_head[22] & (w_dst == peer_dest);
  assign w_hazard  = peer_busy & (w_src_hit | w_dst_hit);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_valid = ~w_empty & ~w_hazard;
  assign w_push  = push_valid & ~w_full & ~flush;
  assign w_pop   = w_valid & core_ready & ~flush;

  // Next-state logic; flush wins over any same-cycle push or pop.
  always_comb begin
    w_nxt_wr_ptr   = r_wr_ptr;
    w_nxt_rd_ptr   = r_rd_ptr;
    w_nxt_count    = r_count;
    w_nxt_overflow = r_overflow | (push_valid & w_full & ~flush);
    w_nxt_stall    = r_stall;
    if (flush) begin
      w_nxt_wr_ptr = '0;
      w_nxt_rd_ptr = '0;
      w_nxt_count  = '0;
    end else begin
      if (w_push) w_nxt_wr_ptr = r_wr_ptr + PTR_W'(1);
      if (w_pop)  w_nxt_rd_ptr = r_rd_ptr + PTR_W'(1);
      w_nxt_count = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
    if (~w_empty && w_hazard && (r_stall != '1)) begin
      w_nxt_stall = r_stall + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_stall    <= '0;
    end else begin
      r_wr_ptr   <= w_nxt_wr_ptr;
      r_rd_ptr   <= w_nxt_rd_ptr;
      r_count    <= w_nxt_count;
      r_overflow <= w_nxt_overflow;
      r_stall    <= w_nxt_stall;
    end
  end

  // Storage needs no reset; reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_instr;
  end

  assign push_ready   = ~w_full;
  assign core_valid   = w_valid;
  assign core_instr   = w_empty ? '0 : w_head;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign overflow     = r_overflow;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_core_dispatch_queue.sv
// Bench for core_dispatch_queue: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations and a randomized soak.
module tb_core_dispatch_queue;

  localparam int unsigned DEPTH   = 32;
  localparam int unsigned PTR_W   = 5;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned STALL_MAX = (1 << STALL_W) - 1;

  logic               clk;
  logic               resetn;
  logic               push_valid;
  logic [31:0]        push_instr;
  logic               push_ready;
  logic               flush;
  logic               core_valid;
  logic [31:0]        core_instr;
  logic               core_ready;
  logic               peer_busy;
  logic [11:0]        peer_dest;
  logic [PTR_W:0]     count;
  logic               full;
  logic               empty;
  logic               overflow;
  logic [STALL_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_err    = 0;

  core_dispatch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .resetn(resetn),
    .push_valid(push_valid), .push_instr(push_instr), .push_ready(push_ready),
    .flush(flush),
    .core_valid(core_valid), .core_instr(core_instr), .core_ready(core_ready),
    .peer_busy(peer_busy), .peer_dest(peer_dest),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Hazard from the field rules, using plain integer arithmetic.
  function automatic bit model_hz(input int unsigned w, input bit pb, input int unsigned pd);
    int unsigned src_mode, dst_mode, src, dst;
    src_mode = (w / (1 << 23)) % 2;
    dst_mode = (w / (1 << 22)) % 2;
    src = src_mode * 2048 + (w % 2048);
    dst = dst_mode * 2048 + ((w / 2048) % 2048);
    return pb && ((src_mode == 0 && src == pd) || (dst_mode == 0 && dst == pd));
  endfunction

  // Reference model state
  int unsigned q[$];
  bit          m_ovf;
  int unsigned m_stall;

  always @(posedge clk or negedge resetn) begin
    bit hz, do_pop, do_push;
    int unsigned sz;
    if (!resetn) begin
      q.delete();
      m_ovf   = 1'b0;
      m_stall = 0;
    end else begin
      sz = q.size();
      hz = (sz > 0) ? model_hz(q[0], peer_busy, int'(peer_dest)) : 1'b0;
      if (sz > 0 && hz && m_stall < STALL_MAX) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        do_pop  = (sz > 0) && !hz && core_ready;
        do_push = push_valid && (sz < DEPTH);
        if (push_valid && sz == DEPTH) m_ovf = 1'b1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(int'(push_instr));
      end
    end
  end

  // Compare process: outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    bit e_empty, e_hz;
    int unsigned e_head;
    e_empty = (q.size() == 0);
    e_head  = e_empty ? 0 : q[0];
    e_hz    = e_empty ? 1'b0 : model_hz(e_head, peer_busy, int'(peer_dest));
    chk("count",        64'(count),        64'(q.size()));
    chk("empty",        64'(empty),        64'(e_empty));
    chk("full",         64'(full),         64'(q.size() == DEPTH));
    chk("push_ready",   64'(push_ready),   64'(q.size() != DEPTH));
    chk("core_valid",   64'(core_valid),   64'(!e_empty && !e_hz));
    chk("core_instr",   64'(core_instr),   64'(e_head));
    chk("overflow",     64'(overflow),     64'(m_ovf));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    push_valid = 1'b0; push_instr = '0; flush = 1'b0;
    core_ready = 1'b0; peer_busy = 1'b0; peer_dest = '0;
  endtask

  initial begin
    logic [31:0] words [3];
    words[0] = 32'h0000_0801; words[1] = 32'h0040_1002; words[2] = 32'h0080_1803;
    resetn = 1'b0;
    idle_inputs();
    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_core_instr", 64'(core_instr), 64'd0);

    // Three pushes, core always ready
    core_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_instr = words[i];
      tick();
      if (i == 0) begin
        chk("first_valid", 64'(core_valid), 64'd1);
        chk("first_instr", 64'(core_instr), 64'h801);
      end
    end
    push_valid = 1'b0;
    tick();
    chk("seq_empty", 64'(empty), 64'd1);

    // Fill to full, drop the 33rd, then drain
    core_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      push_valid = 1'b1; push_instr = 32'(i);
      tick();
      if (i == 31) begin
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_push_ready", 64'(push_ready), 64'd0);
      end
    end
    push_valid = 1'b0;
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(count), 64'd32);
    core_ready = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    chk("drain_empty", 64'(empty), 64'd1);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Hazard on memory SRC
    core_ready = 1'b0; peer_busy = 1'b1; peer_dest = 12'h005;
    push_valid = 1'b1; push_instr = 32'h0000_0005;
    tick();
    push_valid = 1'b0; core_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("hz_valid", 64'(core_valid), 64'd0);
    chk("hz_stall", 64'(stall_cycles), 64'd10);
    peer_busy = 1'b0;
    #1;
    chk("hz_release", 64'(core_valid), 64'd1);
    tick();
    chk("hz_popped", 64'(empty), 64'd1);

    // Both fields register operands: no hazard despite matching bits
    core_ready = 1'b0; peer_busy = 1'b1; peer_dest = 12'h805;
    push_valid = 1'b1; push_instr = 32'h00C0_0005;
    tick();
    push_valid = 1'b0;
    chk("reg_no_hz", 64'(core_valid), 64'd1);
    core_ready = 1'b1;
    tick();
    peer_busy = 1'b0;
    chk("reg_stall_kept", 64'(stall_cycles), 64'd10);

    // Wrap with simultaneous push/pop at occupancy 16
    core_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_valid = 1'b1; push_instr = 32'h1000 + 32'(i);
      tick();
    end
    core_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_instr = 32'h2000 + 32'(i);
      tick();
    end
    push_valid = 1'b0;
    chk("wrap_count", 64'(count), 64'd16);
    chk("wrap_head", 64'(core_instr), 64'h2000 + 64'd24);
    for (int i = 0; i < 16; i++) tick();

    // Flush with a concurrent push
    core_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_valid = 1'b1; push_instr = 32'h3000 + 32'(i);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; push_valid = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_valid", 64'(core_valid), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd1);

    // Randomized soak
    for (int c = 0; c < 2000; c++) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_instr = $urandom;
      core_ready = ($urandom_range(0, 2) != 0);
      peer_busy  = ($urandom_range(0, 1) != 0);
      flush      = ($urandom_range(0, 59) == 0);
      if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 1) != 0)
          peer_dest = {q[0][23], q[0][10:0]};
        else
          peer_dest = {q[0][22], q[0][21:11]};
      end else begin
        peer_dest = 12'($urandom);
      end
      tick();
    end

    // Asynchronous reset in the middle of a push
    idle_inputs();
    core_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_instr = 32'h4000 + 32'(i);
      tick();
    end
    #1;
    resetn = 1'b0;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_valid", 64'(core_valid), 64'd0);
    chk("arst_instr", 64'(core_instr), 64'd0);
    chk("arst_push_ready", 64'(push_ready), 64'd1);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_stall", 64'(stall_cycles), 64'd0);
    tick();
    resetn = 1'b1;
    core_ready = 1'b0;
    push_instr = 32'h5555;
    tick();
    push_valid = 1'b0;
    chk("post_rst_push", 64'(core_instr), 64'h5555);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
